// File: rtl/glyph_plotter.sv
`default_nettype none
// ============================================================================
// Module      : glyph_plotter
// Description : Renders one text cell from a synchronous font ROM into a
//               stream of single-pixel x/y/colour/plot writes, with edge clip.
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_plotter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int GLYPH_W  = 8,
  parameter int GLYPH_H  = 8,
  parameter int CODE_W   = 7,
  parameter int MAX_X    = 320,
  parameter int MAX_Y    = 240,
  localparam int ROW_LOG = $clog2(GLYPH_H),
  localparam int ADDR_W  = CODE_W + ROW_LOG
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CODE_W-1:0]   req_code,
  input  logic [X_W-1:0]      req_x,
  input  logic [Y_W-1:0]      req_y,
  input  logic [COLOUR_W-1:0] req_fg,
  input  logic [COLOUR_W-1:0] req_bg,
  input  logic                req_opaque,
  output logic                font_rd,
  output logic [ADDR_W-1:0]   font_addr,
  input  logic [GLYPH_W-1:0]  font_q,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                done
);

  localparam int ROW_W = (ROW_LOG > 0) ? ROW_LOG : 1;
  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(GLYPH_H - 1);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(GLYPH_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CODE_W-1:0]   r_code;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_fg;
  logic [COLOUR_W-1:0] r_bg;
  logic                r_opaque;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [GLYPH_W-1:0]  r_shift;

  logic                w_col_last;
  logic                w_row_last;
  logic [X_W:0]        w_sum_x;
  logic [Y_W:0]        w_sum_y;
  logic                w_clip;
  logic                w_bit;

  assign w_col_last = (r_col == C_COL_LAST);
  assign w_row_last = (r_row == C_ROW_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_DRAW;
      S_DRAW:  if (w_col_last) w_next = w_row_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_code   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_fg     <= '0;
      r_bg     <= '0;
      r_opaque <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_code   <= req_code;
            r_x      <= req_x;
            r_y      <= req_y;
            r_fg     <= req_fg;
            r_bg     <= req_bg;
            r_opaque <= req_opaque;
            r_row    <= '0;
          end
        end
        S_WAIT: begin
          r_shift <= font_q;
          r_col   <= '0;
        end
        S_DRAW: begin
          r_shift <= r_shift << 1;
          r_col   <= r_col + COL_W'(1);
          if (w_col_last && !w_row_last) r_row <= r_row + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Sums keep one extra bit so a wrap past the port width still clips.
  assign w_sum_x = {1'b0, r_x} + (X_W+1)'(r_col);
  assign w_sum_y = {1'b0, r_y} + (Y_W+1)'(r_row);
  assign w_clip  = (32'(w_sum_x) >= 32'(MAX_X)) || (32'(w_sum_y) >= 32'(MAX_Y));
  assign w_bit   = r_shift[GLYPH_W-1];

  assign vga_x      = w_sum_x[X_W-1:0];
  assign vga_y      = w_sum_y[Y_W-1:0];
  assign vga_colour = w_bit ? r_fg : r_bg;
  assign vga_plot   = (r_state == S_DRAW) && !w_clip && (w_bit || r_opaque);

  assign font_rd   = (r_state == S_FETCH);
  assign font_addr = (ADDR_W'(r_code) << ROW_LOG) | ADDR_W'(r_row);
  assign done      = (r_state == S_DONE);
  assign req_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_glyph_plotter.sv
`default_nettype none
// ============================================================================
// Module      : tb_glyph_plotter
// Description : Randomised self-checking bench for glyph_plotter (8x8 glyphs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glyph_plotter;

  localparam int GW       = 8;
  localparam int GH       = 8;
  localparam int DONE_CYC = GH * (GW + 2) + 1;

  logic       clock;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_code;
  logic [8:0] req_x;
  logic [7:0] req_y;
  logic [2:0] req_fg;
  logic [2:0] req_bg;
  logic       req_opaque;
  logic       font_rd;
  logic [9:0] font_addr;
  logic [7:0] font_q;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int last_plots;

  logic [7:0]  rom [0:1023];
  logic [63:0] exp_q [$];

  glyph_plotter dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_code   (req_code),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_fg     (req_fg),
    .req_bg     (req_bg),
    .req_opaque (req_opaque),
    .font_rd    (font_rd),
    .font_addr  (font_addr),
    .font_q     (font_q),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle-latency font ROM; junk on the bus when not being read.
  always @(posedge clock) font_q <= font_rd ? rom[font_addr] : 8'($urandom);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every pixel {period, x, y, colour} that should be written.
  task automatic build_expected(input int code, input int x, input int y,
                                input int fg, input int bg, input bit op);
    exp_q.delete();
    for (int r = 0; r < GH; r++) begin
      for (int c = 0; c < GW; c++) begin
        int  bm;
        int  sx;
        int  sy;
        bit  px;
        bm = int'(rom[code * GH + r]);
        px = ((bm >> (GW - 1 - c)) & 1) == 1;
        sx = x + c;
        sy = y + r;
        if (sx < 320 && sy < 240 && (px || op))
          exp_q.push_back({16'(3 + r * (GW + 2) + c), 16'(sx % 512), 16'(sy % 256),
                           16'(px ? fg : bg)});
      end
    end
  endtask

  task automatic draw_glyph(input int code, input int x, input int y, input int fg,
                            input int bg, input bit op, input bit hold, input int abort_at);
    logic [63:0] got_q [$];
    int rows_q [$];
    int done_cyc;
    int done_cnt;
    int rdy_hi;
    build_expected(code, x, y, fg, bg, op);
    check("ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_code   = 7'(code);
    req_x      = 9'(x);
    req_y      = 8'(y);
    req_fg     = 3'(fg);
    req_bg     = 3'(bg);
    req_opaque = op;
    @(posedge clock);
    done_cyc = -1;
    done_cnt = 0;
    rdy_hi   = 0;
    for (int n = 1; n <= DONE_CYC; n++) begin
      @(negedge clock);
      if (n == abort_at) begin
        req_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        check("abort_plot", 64'(vga_plot), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_rd", 64'(font_rd), 64'd0);
        return;
      end
      if (vga_plot) got_q.push_back({16'(n), 16'(vga_x), 16'(vga_y), 16'(vga_colour)});
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (font_rd) begin
        rows_q.push_back(int'(font_addr[2:0]));
        check("rd_code", 64'(font_addr[9:3]), 64'(code));
      end
      if (req_ready) rdy_hi++;
      // Request inputs must be ignored while busy.
      req_valid  = hold ? 1'b1 : 1'($urandom);
      req_code   = 7'($urandom);
      req_x      = 9'($urandom);
      req_y      = 8'($urandom);
      req_fg     = 3'($urandom);
      req_bg     = 3'($urandom);
      req_opaque = 1'($urandom);
      if (n == DONE_CYC) req_valid = hold;
    end
    @(negedge clock);
    check("ready_after", 64'(req_ready), 64'd1);
    check("done_after", 64'(done), 64'd0);
    check("done_cyc", 64'(done_cyc), 64'(DONE_CYC));
    check("done_cnt", 64'(done_cnt), 64'd1);
    check("ready_busy", 64'(rdy_hi), 64'd0);
    check("plot_cnt", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("pixel", got_q[i], exp_q[i]);
    check("rd_cnt", 64'(rows_q.size()), 64'(GH));
    for (int i = 0; i < rows_q.size() && i < GH; i++)
      check("rd_row", 64'(rows_q[i]), 64'(i));
    last_plots = got_q.size();
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_code   = '0;
    req_x      = '0;
    req_y      = '0;
    req_fg     = '0;
    req_bg     = '0;
    req_opaque = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int r = 0; r < GH; r++) begin
      rom[8'h41 * GH + r] = 8'h81;
      rom[8'h10 * GH + r] = 8'hFF;
    end

    repeat (3) @(negedge clock);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rd", 64'(font_rd), 64'd0);
    check("rst_addr", 64'(font_addr), 64'd0);
    check("rst_plot", 64'(vga_plot), 64'd0);
    check("rst_xyc", {40'd0, 7'd0, vga_x, vga_y}, 64'd0);
    check("rst_colour", 64'(vga_colour), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    draw_glyph(8'h41, 16, 8, 7, 1, 1'b1, 1'b0, 0);
    check("opaque_plots", 64'(last_plots), 64'd64);
    @(negedge clock);
    draw_glyph(8'h41, 16, 8, 7, 1, 1'b0, 1'b0, 0);
    check("transp_plots", 64'(last_plots), 64'd16);
    draw_glyph(8'h10, 316, 236, 5, 2, 1'b1, 1'b0, 0);
    check("clip_plots", 64'(last_plots), 64'd16);
    @(negedge clock);
    draw_glyph(8'h22, 510, 20, 3, 4, 1'b1, 1'b0, 0);
    check("wrap_plots", 64'(last_plots), 64'd0);
    @(negedge clock);

    draw_glyph(8'h05, 100, 50, 6, 0, 1'b1, 1'b1, 0);
    draw_glyph(8'h41, 200, 120, 2, 3, 1'b1, 1'b0, 0);

    @(negedge clock);
    draw_glyph(8'h41, 40, 40, 7, 1, 1'b1, 1'b0, 40);
    repeat (3) begin
      @(negedge clock);
      check("rst_hold_plot", 64'(vga_plot), 64'd0);
      check("rst_hold_done", 64'(done), 64'd0);
    end
    resetn = 1'b1;
    @(negedge clock);
    draw_glyph(8'h41, 60, 30, 4, 5, 1'b1, 1'b0, 0);
    check("post_rst_plots", 64'(last_plots), 64'd64);

    for (int t = 0; t < 20; t++) begin
      int rx;
      int ry;
      rx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 511));
      ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(225, 255)) : int'($urandom_range(0, 255));
      draw_glyph(int'($urandom_range(0, 127)), rx, ry, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 0);
      if (!req_valid) repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glyph_plotter.md
# glyph_plotter

Parametrised character renderer that converts one text-cell request (character code, pixel origin, colours, mode) into a stream of single-pixel writes for the VGA adapter's x/y/colour/plot port. It reads the glyph bitmap one row at a time from an external synchronous font ROM. It generalises the fixed 320x240 / 3-bit-colour typing display to any frame size, glyph size and colour depth, and adds opaque/transparent modes and screen-edge clipping. It sits between the game controller (request side) and the VGA adapter (pixel side).

## Interface
- X_W, 9: width of x coordinates.
- Y_W, 8: width of y coordinates.
- COLOUR_W, 3: colour width.
- GLYPH_W, 8: glyph width in pixels (1..16).
- GLYPH_H, 8: glyph height in rows; power of two (1..16).
- CODE_W, 7: character code width.
- MAX_X, 320: frame width; pixels with x >= MAX_X are clipped.
- MAX_Y, 240: frame height; pixels with y >= MAX_Y are clipped.
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and accepting requests.
- req_code  in  CODE_W  character code.
- req_x  in  X_W  glyph top-left x.
- req_y  in  Y_W  glyph top-left y.
- req_fg  in  COLOUR_W  foreground colour.
- req_bg  in  COLOUR_W  background colour.
- req_opaque  in  1  1 = paint background pixels, 0 = skip them.
- font_rd  out  1  font ROM read strobe.
- font_addr  out  CODE_W+log2(GLYPH_H)  {code, row}.
- font_q  in  GLYPH_W  row bitmap, valid one cycle after font_rd; bit GLYPH_W-1 is the leftmost pixel.
- vga_x  out  X_W  pixel x.
- vga_y  out  Y_W  pixel y.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  write pixel this cycle.
- done  out  1  one-cycle pulse when a glyph completes.

## Operation
- States: IDLE, FETCH, WAIT, DRAW, DONE.
- IDLE: req_ready=1. When req_valid is high at a clock edge, the block latches code, x, y, fg, bg and opaque, sets row=0, and moves to FETCH. Request inputs are ignored in every other state.
- FETCH: font_rd=1, font_addr={code,row}. Next state is WAIT.
- WAIT: font_q is captured into the row shift register at the end of this cycle. col is set to 0. Next state is DRAW.
- DRAW: lasts exactly GLYPH_W cycles, one per column.
  - vga_x = x+col and vga_y = y+row, both truncated to port width.
  - Pixel bit is shift-register MSB; the register shifts left each cycle.
  - Bit 1 → colour=fg, plot=1.
  - Bit 0 → colour=bg; plot=opaque.
  - plot is forced to 0 when the untruncated sum x+col (X_W+1 bits) >= MAX_X or y+row (Y_W+1 bits) >= MAX_Y. Clipped pixels still consume their cycle.
  - After col=GLYPH_W-1: if row=GLYPH_H-1, go to DONE; otherwise row+1 and go to FETCH.
- DONE: done=1, req_ready=0. Next state is IDLE.
- vga_plot=0 in every state other than DRAW. vga_x, vga_y and vga_colour are don't-care when plot=0 but must not be X after reset.
- Reset values: state IDLE, req_ready=1, font_rd=0, font_addr=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, done=0. Asserting reset mid-glyph aborts immediately; no further plot or done is produced.

## Timing
- Request accepted at edge 0 (cycle 0).
- Row r timing: FETCH at cycle 1+r(GLYPH_W+2), WAIT at the next cycle, DRAW for the GLYPH_W cycles after that.
- DONE at cycle GLYPH_H(GLYPH_W+2)+1. IDLE (req_ready=1) the cycle after DONE.
- Defaults (8x8 glyph): row 0 pixels at cycles 3..10, last pixel at cycle 80, done at cycle 81, next request acceptable at edge 82.
- Fixed throughput: GLYPH_H(GLYPH_W+2)+2 cycles per glyph, independent of bitmap content, mode or clipping.
- Font ROM must have exactly one cycle of read latency.

## Test plan
- Opaque glyph: 8x8 defaults; code 0x41, x=16, y=8, fg=7, bg=1, font row bitmap 0x81 for all rows. Required: 64 plots; x=16 and x=23 get colour 7, x=17..22 get colour 1; y=8..15; done at cycle 81.
- Transparent glyph: same stimulus with opaque=0. Required: exactly 16 plots, all with colour 7, at x∈{16,23}; done still at cycle 81.
- Clipping: x=316, y=236, opaque=1, all bitmaps 0xFF. Required: plots only for x 316..319 and y 236..239 (16 pixels); no plot with x>=320 or y>=240.
- Wrap at X_W: x=510, opaque=1. Required: zero plots, since the 10-bit sums are >= 320; done at cycle 81.
- Back-to-back: req_valid held high for two requests. Required: second accept at edge 82, ready low throughout the first glyph, font_addr row field sequence 0..7 for each glyph.
- Reset mid-glyph: assert resetn=0 at cycle 40. Required: plot=0 and done=0 immediately; after release, ready=1 and a fresh request renders correctly.
